// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32M multiply/divide types and constants
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

  localparam int          MULDIV_ITERS  = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, 32 iterations per op
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  muldiv_state_e   state_q;
  muldiv_op_e      op_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] acc_q;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q;    // multiplier being consumed / dividend becoming quotient
  logic [XLEN-1:0] mag_q;   // |a| for multiply, |b| for divide
  logic            neg_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_result_q;
  logic            busy_q;

  muldiv_op_e      op_in;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_d;

  always_comb begin
    op_in = muldiv_op_e'(req_op);
    a_neg = op_a_signed(op_in) & req_a[XLEN-1];
    b_neg = op_b_signed(op_in) & req_b[XLEN-1];
    a_mag = a_neg ? (~req_a + 1'b1) : req_a;
    b_mag = b_neg ? (~req_b + 1'b1) : req_b;
    neg_d = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   acc_d, lo_d;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, mag_q});
    if (op_q[2]) begin
      acc_d = div_ge ? XLEN'(div_shift - {1'b0, mag_q}) : div_shift[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      acc_d = mul_sum[XLEN:1];
      lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    // Sign fix is applied to the values of the final iteration so DONE is reached without an extra cycle.
    prod     = {acc_d, lo_d};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    quot_fix = neg_q ? (~lo_d + 1'b1) : lo_d;
    rem_fix  = neg_q ? (~acc_d + 1'b1) : acc_d;
    case (op_q)
      OP_MUL:                      final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res = quot_fix;
      default:                     final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= OP_MUL;
      cnt_q         <= '0;
      acc_q         <= '0;
      lo_q          <= '0;
      mag_q         <= '0;
      neg_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= op_in;
            neg_q       <= neg_d;
            cnt_q       <= 5'(MULDIV_ITERS - 1);
            acc_q       <= '0;
            mag_q       <= req_op[2] ? b_mag : a_mag;
            lo_q        <= req_op[2] ? a_mag : b_mag;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_op[2] && (req_b == '0)) begin
              state_q       <= S_DONE;
              resp_valid_q  <= 1'b1;
              resp_result_q <= req_op[1] ? req_a : DIV_BY_ZERO_Q;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q       <= S_DONE;
            resp_valid_q  <= 1'b1;
            resp_result_q <= final_res;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .busy(busy)
  );

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
    return (op[2] && b == 0) ? 1 : 33;
  endfunction

  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (req_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    accept(op, a, b);
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
    wait_resp(lat);
    res = resp_result;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL reset_resp_valid: got %b required 0", resp_valid); end
    n_cmp++; if (resp_result !== 32'd0) begin n_mis++; $display("FAIL reset_resp_result: got %h required 0", resp_result); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_directed;
    logic [2:0]  ops  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6, 3'd6};
    logic [31:0] as   [12] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] bs   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd16, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] exps [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'h0FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFB};
    int          lats [12] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 33, 33, 1};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      n_cmp++;
      if (res !== exps[i]) begin
        n_mis++; $display("FAIL directed_result[%0d]: got %h required %h", i, res, exps[i]);
      end
      n_cmp++;
      if (lat != lats[i]) begin
        n_mis++; $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, lats[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] pool [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
    logic [2:0]  op;
    logic [31:0] a, b, res;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
      run_op(op, a, b, res, lat);
      n_cmp++;
      if (res !== ref_model(op, a, b)) begin
        n_mis++; $display("FAIL random_result op=%0d a=%h b=%h: got %h required %h", op, a, b, res, ref_model(op, a, b));
      end
      n_cmp++;
      if (lat != ref_latency(op, b)) begin
        n_mis++; $display("FAIL random_latency op=%0d: got %0d required %0d", op, lat, ref_latency(op, b));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp;
    int          lat;
    exp = ref_model(3'd0, 32'd12345, 32'hFFFF_0001);
    accept(3'd0, 32'd12345, 32'hFFFF_0001);
    req_valid = 1'b0;
    wait_resp(lat);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_result !== exp || req_ready !== 1'b0 || busy !== 1'b1) begin
        n_mis++;
        $display("FAIL backpressure_hold[%0d]: valid=%b result=%h ready=%b busy=%b required 1 %h 0 1",
                 i, resp_valid, resp_result, req_ready, busy, exp);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_mis++; $display("FAIL backpressure_release: ready=%b valid=%b required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ops [8];
    logic [31:0] as [8], bs [8];
    int          lat;
    for (int i = 0; i < 8; i++) begin
      ops[i] = 3'($urandom_range(0, 7));
      as[i]  = $urandom;
      bs[i]  = (i == 3) ? 32'd0 : $urandom;
    end
    for (int i = 0; i < 8; i++) begin
      accept(ops[i], as[i], bs[i]);
      // keep req_valid high with the next request while this one computes
      req_op = ops[(i + 1) % 8]; req_a = as[(i + 1) % 8]; req_b = bs[(i + 1) % 8];
      if (i == 7) req_valid = 1'b0;
      wait_resp(lat);
      n_cmp++;
      if (resp_result !== ref_model(ops[i], as[i], bs[i]) || lat != ref_latency(ops[i], bs[i])) begin
        n_mis++;
        $display("FAIL back_to_back[%0d]: result=%h lat=%0d required %h %0d", i, resp_result, lat,
                 ref_model(ops[i], as[i], bs[i]), ref_latency(ops[i], bs[i]));
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      n_cmp++;
      if (req_ready !== 1'b1) begin
        n_mis++; $display("FAIL back_to_back_ready[%0d]: got %b required 1", i, req_ready);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int          lat;
    int          stale;
    accept(3'd4, 32'd1000, 32'd7);
    req_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_mis++; $display("FAIL reset_mid_state: valid=%b ready=%b busy=%b required 0 1 0", resp_valid, req_ready, busy);
    end
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_mis++; $display("FAIL reset_mid_stale: got %0d valid cycles required 0", stale);
    end
    run_op(3'd7, 32'd1000, 32'd7, res, lat);
    n_cmp++;
    if (res !== 32'd6) begin
      n_mis++; $display("FAIL reset_mid_recover: got %h required %h", res, 32'd6);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide responder that sits beside the single-cycle ALU in the execute stage. The ALU answers every op combinationally in the same cycle. This block is the multi-cycle end of the same execute-operation interface: it accepts an op plus two operands via a valid/ready request, iterates, and returns a 32-bit result via a valid/ready response. The core stalls on req_ready/resp_valid.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_a  input  XLEN  rs1 operand
req_b  input  XLEN  rs2 operand
resp_valid  output  1  result present
resp_ready  input  1  consumer takes result
resp_result  output  XLEN  result
busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, busy=0, all internal registers 0.
- Reset mid-operation: abandons the operation; no response is produced.
- State machine, states IDLE, CALC, DONE:
  - IDLE: req_ready=1. On req_valid, latch op, operand magnitudes, sign flags and a count of 31, then go to CALC.
  - IDLE fast path: a division-family op (1xx) with req_b==0 goes directly to DONE. DIV/DIVU return 0xFFFF_FFFF; REM/REMU return req_a.
  - CALC: performs one iteration per cycle, 32 cycles total, then goes to DONE.
  - DONE: resp_valid=1 and resp_result is held stable. If resp_ready is high, go to IDLE; otherwise stay.
- Handshake rules:
  - req_ready is high only in IDLE.
  - A request is accepted on a cycle where req_valid and req_ready are both high.
  - resp_valid never deasserts without a resp_ready handshake.
  - No new request is accepted in the same cycle as a response handshake; req_ready rises on the following cycle.
- Latency from the accept edge to the first resp_valid cycle:
  - 33 cycles for normal ops.
  - 1 cycle for divide-by-zero.
- Multiply:
  - Operand signedness: MUL/MULH treat both operands as signed, MULHSU treats a as signed and b as unsigned, MULHU treats both as unsigned.
  - Datapath: unsigned shift-add on 32-bit magnitudes into a 64-bit product.
  - Sign fix: the 64-bit product is negated if the operand signs differ.
  - Result selection: MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide:
  - Datapath: restoring division on 32-bit magnitudes (signed ops take |a|, |b|), 33-bit partial remainder.
  - Quotient sign: negated when a and b signs differ (DIV only).
  - Remainder sign: takes the sign of a (REM only).
- Signed overflow: DIV with a=0x8000_0000 and b=0xFFFF_FFFF returns 0x8000_0000; REM with the same operands returns 0. The general datapath already yields these values, and the bench must check them.
- Magnitude of 0x8000_0000 is 0x8000_0000, treated as unsigned 32-bit.
- Operands change after accept: no effect on the operation in progress.

Decomposition:
- Shared package riscv_pkg:
  - muldiv_op_e enum (3-bit, values as in the req_op port).
  - MULDIV_ITERS=32 constant.
  - DIV_BY_ZERO_Q=32'hFFFF_FFFF constant.
- Sub-modules: none required. The single FSM plus datapath fits in one module.

Test Plan:
- MUL 7×(−3) (a=7, b=0xFFFF_FFFD) -> resp_result 0xFFFF_FFEB, resp_valid 33 cycles after accept.
- MULH a=0x8000_0000, b=0x8000_0000 -> 0x4000_0000; same operands with MULHU -> 0x4000_0000; MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV −7/2 -> 0xFFFF_FFFD. REM −7/2 -> 0xFFFF_FFFF. DIVU 0xFFFF_FFFF/16 -> 0x0FFF_FFFF.
- DIV 5/0 -> 0xFFFF_FFFF after 1 cycle; REMU 5/0 -> 5. DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM with the same operands -> 0.
- Back-pressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_result stable and req_ready=0. Then raise resp_ready -> req_ready=1 the next cycle. Back-to-back requests are accepted with no loss.
- Drop rst_n to 0 at CALC iteration 15 -> next cycle state IDLE, resp_valid=0, req_ready=1; no stale response appears afterwards.
